// File: rtl/ctrl_mc_pkg.sv
// rtl/ctrl_mc_pkg.sv - opcodes, state encoding and control-field encodings for the multicycle control unit
package ctrl_mc_pkg;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] ADDIU    = 6'd9;
  localparam logic [5:0] MADDU    = 6'd28;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_R_WB      = 4'd4,
    S_MADD_EXEC = 4'd5,
    S_EXEC_I    = 4'd6,
    S_I_WB      = 4'd7,
    S_MEM_ADDR  = 4'd8,
    S_MEM_READ  = 4'd9,
    S_MEM_WB    = 4'd10,
    S_MEM_WRITE = 4'd11,
    S_BRANCH    = 4'd12,
    S_JUMP      = 4'd13,
    S_TRAP      = 4'd14
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == R_FORMAT) || (op == J) || (op == BEQ) || (op == ADDIU) ||
           (op == MADDU) || (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/control_mc_outdec.sv
// rtl/control_mc_outdec.sv - state (+ mem_ready gating) to datapath control decoder
module control_mc_outdec
  import ctrl_mc_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   decode_nop_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC advance only on the cycle the fetch actually completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.instr_done = decode_nop_i;
      end
      S_EXEC_R, S_MADD_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_multicycle.sv
// rtl/control_multicycle.sv - multicycle MIPS control FSM; CTRL_TRAP_ILLEGAL_EN adds TRAP state and illegal_op
module control_multicycle
  import ctrl_mc_pkg::*;
#(
  parameter int MADDU_CYCLES = 4,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
`ifdef CTRL_TRAP_ILLEGAL_EN
  ,
  output logic               illegal_op
`endif
);

  localparam int CNT_W = (MADDU_CYCLES > 1) ? $clog2(MADDU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MADDU_CYCLES - 1);

  state_e           state_q;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] mul_cnt_q;
  logic             decode_nop;
  ctrl_t            ctrl;

`ifdef CTRL_TRAP_ILLEGAL_EN
  assign decode_nop = 1'b0;
  assign illegal_op = (state_q == S_TRAP);
`else
  assign decode_nop = (state_q == S_DECODE) && !is_known_op(opcode);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mul_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q      <= opcode;
          mul_cnt_q <= '0;
          case (opcode)
            R_FORMAT: state_q <= S_EXEC_R;
            MADDU:    state_q <= S_MADD_EXEC;
            ADDIU:    state_q <= S_EXEC_I;
            LW, SW:   state_q <= S_MEM_ADDR;
            BEQ:      state_q <= S_BRANCH;
            J:        state_q <= S_JUMP;
`ifdef CTRL_TRAP_ILLEGAL_EN
            default:  state_q <= S_TRAP;
`else
            default:  state_q <= S_FETCH;
`endif
          endcase
        end
        S_EXEC_R: state_q <= S_R_WB;
        S_MADD_EXEC: begin
          mul_cnt_q <= mul_cnt_q + CNT_W'(1);
          if (mul_cnt_q == CNT_LAST) state_q <= S_R_WB;
        end
        S_EXEC_I:    state_q <= S_I_WB;
        // the decoded opcode is latched, so a changing IR field cannot redirect the access
        S_MEM_ADDR:  state_q <= (op_q == LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) state_q <= S_FETCH;
        S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_q <= S_FETCH;
        S_TRAP:      state_q <= S_TRAP;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  control_mc_outdec u_outdec (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready),
    .decode_nop_i (decode_nop),
    .ctrl_o       (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_control_multicycle.sv
// tb/tb_control_multicycle.sv - directed-vector bench for control_multicycle (MADDU_CYCLES 4 and 1)
module tb_control_multicycle;
  import ctrl_mc_pkg::*;

  // field order: pw pwc iord mr mw irw m2r rdst rw asa asb[2] aop[2] psrc[2] done
  localparam logic [16:0] E_ZERO       = 17'd0;
  localparam logic [16:0] E_FETCH_W    = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_FETCH_R    = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DECODE     = {9'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_DECODE_NOP = {9'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] E_EXEC_R     = {9'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] E_R_WB       = {7'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [16:0] E_EXEC_I     = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] E_I_WB       = {7'b0, 1'b0, 1'b1, 1'b0, 6'b0, 1'b1};
  localparam logic [16:0] E_MEM_READ   = {2'b00, 1'b1, 1'b1, 5'b0, 1'b0, 6'b0, 1'b0};
  localparam logic [16:0] E_MEM_WB     = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 1'b1};
  localparam logic [16:0] E_MEM_WR_W   = {2'b00, 1'b1, 1'b0, 1'b1, 4'b0, 1'b0, 6'b0, 1'b0};
  localparam logic [16:0] E_MEM_WR_R   = {2'b00, 1'b1, 1'b0, 1'b1, 4'b0, 1'b0, 6'b0, 1'b1};
  localparam logic [16:0] E_BRANCH     = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1};
  localparam logic [16:0] E_JUMP       = {1'b1, 8'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mem_ready;
  logic [5:0] opcode;
  logic       a_pw, a_pwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rdst, a_rw, a_asa, a_done;
  logic [1:0] a_asb, a_aop, a_psrc;
  logic [3:0] a_state;
`ifdef CTRL_TRAP_ILLEGAL_EN
  logic       a_illegal;
`endif

  logic       rst1, mem_ready1;
  logic [5:0] opcode1;
  logic       b_pw, b_pwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rdst, b_rw, b_asa, b_done;
  logic [1:0] b_asb, b_aop, b_psrc;
  logic [3:0] b_state;
`ifdef CTRL_TRAP_ILLEGAL_EN
  logic       b_illegal;
`endif

  int n_vec = 0;
  int n_err = 0;

  control_multicycle #(.MADDU_CYCLES(4), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pw), .pc_write_cond(a_pwc), .i_or_d(a_iord), .mem_read(a_mr),
    .mem_write(a_mw), .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rdst),
    .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb), .alu_op(a_aop),
    .pc_source(a_psrc), .instr_done(a_done), .state(a_state)
`ifdef CTRL_TRAP_ILLEGAL_EN
    , .illegal_op(a_illegal)
`endif
  );

  control_multicycle #(.MADDU_CYCLES(1), .STATE_W(4)) dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode1), .mem_ready(mem_ready1),
    .pc_write(b_pw), .pc_write_cond(b_pwc), .i_or_d(b_iord), .mem_read(b_mr),
    .mem_write(b_mw), .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rdst),
    .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb), .alu_op(b_aop),
    .pc_source(b_psrc), .instr_done(b_done), .state(b_state)
`ifdef CTRL_TRAP_ILLEGAL_EN
    , .illegal_op(b_illegal)
`endif
  );

  function automatic logic [16:0] ctl_a();
    return {a_pw, a_pwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rdst, a_rw, a_asa,
            a_asb, a_aop, a_psrc, a_done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_e st, input logic [16:0] ctl);
    chk({tag, ".state"}, 32'(a_state), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl_a()), 32'(ctl));
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = R_FORMAT;
    rst1 = 1'b1; mem_ready1 = 1'b1; opcode1 = MADDU;
    step(); step();
    chk_st("reset", S_IDLE, E_ZERO);
    rst = 1'b0;

    step(); chk_st("r.fetch", S_FETCH, E_FETCH_R);
    step(); chk_st("r.decode", S_DECODE, E_DECODE);
    step(); chk_st("r.exec", S_EXEC_R, E_EXEC_R);
    step(); chk_st("r.wb", S_R_WB, E_R_WB);

    mem_ready = 1'b0; opcode = LW;
    step(); chk_st("lw.fetch_w1", S_FETCH, E_FETCH_W);
    step(); chk_st("lw.fetch_w2", S_FETCH, E_FETCH_W);
    step(); chk_st("lw.fetch_w3", S_FETCH, E_FETCH_W);
    step(); mem_ready = 1'b1; #1;
    chk_st("lw.fetch_rdy", S_FETCH, E_FETCH_R);
    step(); chk_st("lw.decode", S_DECODE, E_DECODE);
    step(); chk_st("lw.addr", S_MEM_ADDR, E_EXEC_I);
    opcode = SW; mem_ready = 1'b0;
    step(); chk_st("lw.mrd_w1", S_MEM_READ, E_MEM_READ);
    step(); chk_st("lw.mrd_w2", S_MEM_READ, E_MEM_READ);
    mem_ready = 1'b1; #1;
    chk_st("lw.mrd_rdy", S_MEM_READ, E_MEM_READ);
    step(); chk_st("lw.wb", S_MEM_WB, E_MEM_WB);
    step(); chk_st("lw.next_fetch", S_FETCH, E_FETCH_R);

    opcode = SW;
    step(); chk_st("sw.decode", S_DECODE, E_DECODE);
    step(); chk_st("sw.addr", S_MEM_ADDR, E_EXEC_I);
    opcode = LW; mem_ready = 1'b0;
    step(); chk_st("sw.write_w", S_MEM_WRITE, E_MEM_WR_W);
    mem_ready = 1'b1; #1;
    chk_st("sw.write_rdy", S_MEM_WRITE, E_MEM_WR_R);
    step(); chk_st("sw.next_fetch", S_FETCH, E_FETCH_R);

    opcode = ADDIU;
    step(); chk_st("addiu.decode", S_DECODE, E_DECODE);
    step(); chk_st("addiu.exec", S_EXEC_I, E_EXEC_I);
    step(); chk_st("addiu.wb", S_I_WB, E_I_WB);
    step(); chk_st("addiu.next_fetch", S_FETCH, E_FETCH_R);

    opcode = BEQ;
    step(); chk_st("beq.decode", S_DECODE, E_DECODE);
    step(); chk_st("beq.branch", S_BRANCH, E_BRANCH);
    step(); chk_st("beq.next_fetch", S_FETCH, E_FETCH_R);
    opcode = J;
    step(); chk_st("j.decode", S_DECODE, E_DECODE);
    step(); chk_st("j.jump", S_JUMP, E_JUMP);
    step(); chk_st("j.next_fetch", S_FETCH, E_FETCH_R);

    opcode = MADDU;
    step(); chk_st("maddu.decode", S_DECODE, E_DECODE);
    step(); chk_st("maddu.exec1", S_MADD_EXEC, E_EXEC_R);
    step(); chk_st("maddu.exec2", S_MADD_EXEC, E_EXEC_R);
    step(); chk_st("maddu.exec3", S_MADD_EXEC, E_EXEC_R);
    step(); chk_st("maddu.exec4", S_MADD_EXEC, E_EXEC_R);
    step(); chk_st("maddu.wb", S_R_WB, E_R_WB);
    step(); chk_st("maddu.next_fetch", S_FETCH, E_FETCH_R);

    step(); chk_st("rstmid.decode", S_DECODE, E_DECODE);
    step(); chk_st("rstmid.exec1", S_MADD_EXEC, E_EXEC_R);
    step(); chk_st("rstmid.exec2", S_MADD_EXEC, E_EXEC_R);
    rst = 1'b1;
    step(); chk_st("rstmid.idle", S_IDLE, E_ZERO);
    rst = 1'b0;
    step(); chk_st("rstmid.fetch", S_FETCH, E_FETCH_R);

    opcode = 6'd63;
`ifdef CTRL_TRAP_ILLEGAL_EN
    step(); chk_st("illegal.decode", S_DECODE, E_DECODE);
    step(); chk_st("illegal.trap", S_TRAP, E_ZERO);
    chk("illegal.flag", 32'(a_illegal), 32'd1);
    step(); chk_st("illegal.trap_hold", S_TRAP, E_ZERO);
`else
    step(); chk_st("nop.decode", S_DECODE, E_DECODE_NOP);
    step(); chk_st("nop.next_fetch", S_FETCH, E_FETCH_R);
`endif

    rst1 = 1'b0;
    step(); chk("m1.fetch", 32'(b_state), 32'(S_FETCH));
    step(); chk("m1.decode", 32'(b_state), 32'(S_DECODE));
    step(); chk("m1.exec", 32'(b_state), 32'(S_MADD_EXEC));
    chk("m1.alu_op", 32'(b_aop), 32'd2);
    step(); chk("m1.wb", 32'(b_state), 32'(S_R_WB));
    chk("m1.reg_write", 32'(b_rw), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
